// File: rtl/fpadd_share_ctrl.sv
// Round-robin sequencer sharing one external combinational FP64 adder among NREQ requesters.
// Optional result classification flags are enabled with `define FPADD_SHARE_FLAGS_EN.
module fpadd_share_ctrl #(
    parameter int NREQ    = 2,
    parameter int ADD_LAT = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ-1:0]      req_sub,
    input  logic [64*NREQ-1:0]   req_a,
    input  logic [64*NREQ-1:0]   req_b,
    output logic [NREQ-1:0]      resp_valid,
    input  logic [NREQ-1:0]      resp_ready,
    output logic [63:0]          resp_data,
    output logic                 busy,
    output logic [63:0]          fpa_a,
    output logic [63:0]          fpa_b,
    input  logic [63:0]          fpa_out
`ifdef FPADD_SHARE_FLAGS_EN
    ,
    output logic [1:0]           resp_flags
`endif
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = (ADD_LAT > 1) ? $clog2(ADD_LAT) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [PW-1:0]     rr_ptr_q, rr_ptr_d;
    logic [PW-1:0]     owner_q, owner_d;
    logic [CW-1:0]     count_q, count_d;
    logic [63:0]       fpa_a_q, fpa_a_d;
    logic [63:0]       fpa_b_q, fpa_b_d;
    logic [63:0]       resp_data_q, resp_data_d;
    logic [NREQ-1:0]   resp_valid_q, resp_valid_d;

    logic              gnt_found;
    logic [PW-1:0]     gnt_idx;

`ifdef FPADD_SHARE_FLAGS_EN
    logic [1:0]        flags_q, flags_d;

    // {NaN, Inf} classification of an IEEE-754 double.
    function automatic logic [1:0] classify(input logic [63:0] x);
        logic exp_max;
        logic man_zero;
        exp_max  = &x[62:52];
        man_zero = ~|x[51:0];
        return {exp_max & ~man_zero, exp_max & man_zero};
    endfunction
`endif

    // First valid requester at or after rr_ptr, wrapping modulo NREQ.
    always_comb begin
        int idx;
        idx       = 0;
        gnt_found = 1'b0;
        gnt_idx   = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = (int'(rr_ptr_q) + k) % NREQ;
            if (!gnt_found && req_valid[idx]) begin
                gnt_found = 1'b1;
                gnt_idx   = PW'(idx);
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (state_q == IDLE && gnt_found) begin
            req_ready[gnt_idx] = 1'b1;
        end
    end

    always_comb begin
        state_d      = state_q;
        rr_ptr_d     = rr_ptr_q;
        owner_d      = owner_q;
        count_d      = count_q;
        fpa_a_d      = fpa_a_q;
        fpa_b_d      = fpa_b_q;
        resp_data_d  = resp_data_q;
        resp_valid_d = resp_valid_q;
`ifdef FPADD_SHARE_FLAGS_EN
        flags_d      = flags_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (gnt_found) begin
                    // SUB only flips the sign of B; NaN payloads pass untouched.
                    fpa_a_d  = req_a[int'(gnt_idx)*64 +: 64];
                    fpa_b_d  = {req_b[int'(gnt_idx)*64 + 63] ^ req_sub[gnt_idx],
                                req_b[int'(gnt_idx)*64 +: 63]};
                    owner_d  = gnt_idx;
                    rr_ptr_d = (gnt_idx == PW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
                    count_d  = '0;
                    state_d  = EXEC;
                end
            end
            EXEC: begin
                if (count_q == CW'(ADD_LAT - 1)) begin
                    resp_data_d           = fpa_out;
                    resp_valid_d          = '0;
                    resp_valid_d[owner_q] = 1'b1;
`ifdef FPADD_SHARE_FLAGS_EN
                    flags_d               = classify(fpa_out);
`endif
                    state_d               = RESP;
                end else begin
                    count_d = count_q + 1'b1;
                end
            end
            RESP: begin
                if (resp_ready[owner_q]) begin
                    resp_valid_d = '0;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            rr_ptr_q     <= '0;
            owner_q      <= '0;
            count_q      <= '0;
            fpa_a_q      <= '0;
            fpa_b_q      <= '0;
            resp_data_q  <= '0;
            resp_valid_q <= '0;
`ifdef FPADD_SHARE_FLAGS_EN
            flags_q      <= '0;
`endif
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            owner_q      <= owner_d;
            count_q      <= count_d;
            fpa_a_q      <= fpa_a_d;
            fpa_b_q      <= fpa_b_d;
            resp_data_q  <= resp_data_d;
            resp_valid_q <= resp_valid_d;
`ifdef FPADD_SHARE_FLAGS_EN
            flags_q      <= flags_d;
`endif
        end
    end

    assign fpa_a      = fpa_a_q;
    assign fpa_b      = fpa_b_q;
    assign resp_data  = resp_data_q;
    assign resp_valid = resp_valid_q;
    assign busy       = (state_q != IDLE);
`ifdef FPADD_SHARE_FLAGS_EN
    assign resp_flags = flags_q;
`endif

endmodule
